weight_update: RTL and testbench
================================

Name: weight_update

Overview:
- Consumes the per-row dc_dw_stream produced by the backprop gradient stack and applies an SGD step to the weight matrix of one layer: w = w - (dc_dw >>> LR_SHIFT).
- Holds the weight store for all layers, MAX_LAYER_SIZE x SIZE x SIZE entries.
- Exposes a combinational row read port for the forward dense stage, and a load port for initialisation.

Parameters:
- DATA_SIZE, 4, bit width of one weight/gradient element
- SIZE, 3, neurons per layer; matrix is SIZE x SIZE, stream carries one row (SIZE elements)
- MAX_LAYER_SIZE, 4, number of layers stored
- LR_SHIFT, 1, learning rate expressed as an arithmetic right shift of the gradient

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin an update of layer start_layer; accepted only in IDLE
- start_layer  in  33  target layer index
- dc_dw_valid  in  1  dc_dw_stream beat valid
- dc_dw_stream  in  DATA_SIZE*SIZE  one gradient row; column c at bits [(SIZE-c)*DATA_SIZE-1 -: DATA_SIZE]
- dc_dw_ready  out  1  high in ACCUM only
- load_en  in  1  weight write; honoured only in IDLE
- load_layer  in  33  layer to write
- load_row  in  33  row to write
- load_data  in  DATA_SIZE*SIZE  row data, same packing as the stream
- rd_layer  in  33  read layer
- rd_row  in  33  read row
- rd_data  out  DATA_SIZE*SIZE  combinational read of the stored row; 0 if the index is out of range
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the update completes
- err  out  1  one-cycle pulse when start is rejected because start_layer >= MAX_LAYER_SIZE

Behaviour:
- Reset (reset=0, asynchronous):
  - all weights = 0, grad buffer = 0
  - state = IDLE; row counter = 0
  - busy=0, done=0, err=0, dc_dw_ready=0
- FSM states: IDLE, ACCUM, APPLY, DONE.
- IDLE:
  - start with start_layer < MAX_LAYER_SIZE: latch the layer, clear the row counter, go to ACCUM.
  - start with start_layer out of range: err=1 for the next cycle, stay in IDLE, no state change.
  - load_en with both indices in range: row written at the edge. An out-of-range load is dropped.
  - If start and load_en arrive together, both take effect (load completes before APPLY begins).
- ACCUM:
  - Each edge with dc_dw_valid=1 stores the stream into grad_buf[row] and increments row.
  - After row SIZE-1 is captured, go to APPLY with row=0.
  - valid=0 inserts stall cycles; there is no timeout.
- APPLY: one row per cycle, SIZE cycles. For each element, w[layer][row][c] <= w - (grad >>> LR_SHIFT).
  - Operands are signed two's complement, DATA_SIZE bits.
  - Result wraps modulo 2^DATA_SIZE (see Optional Feature).
  - The row written at edge k is visible on rd_data after that edge.
- DONE: lasts one cycle with done=1, then returns to IDLE.
- Latency: with valid held high, done is high in the cycle after 2*SIZE+1 edges counted from the start edge.
- Ignored inputs:
  - start, load_en while busy
  - dc_dw_valid outside ACCUM
- Reset asserted mid-operation aborts the update. Weights return to 0 regardless of partial writes.
- rd_data is always served, including while busy.

Optional Feature:
- Macro: WEIGHT_SATURATE_EN.
- Defined: the subtraction saturates to the signed range [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- Undefined: the result wraps modulo 2^DATA_SIZE.

Decomposition:
- Package weight_update_pkg holds:
  - state enum (IDLE, ACCUM, APPLY, DONE)
  - index width constant (33)
  - pack/unpack helper functions for the column ordering
- Sub-module weight_row_update: combinational update of SIZE elements (shift, subtract, optional saturation), instantiated once and fed the current APPLY row.

Test Plan:
- Reset, then read layer 0 row 0 -> rd_data=0; busy=0, done=0, err=0.
- Load layer 1 row 0 = {8,8,8}; start layer 1; stream {2,4,6},{0,0,0},{0,0,0} with valid held high -> row 0 = {7,6,5}, rows 1 and 2 unchanged; done pulses exactly once, 7 edges after the start edge.
- Load w=9 (-7); stream gradient 6 -> without macro result 6 (wrap); with WEIGHT_SATURATE_EN result 8 (-8).
- start_layer=4 with MAX_LAYER_SIZE=4 -> err pulses one cycle, busy stays 0, weights unchanged.
- Stall: deassert valid for 3 cycles between beats 1 and 2 -> result identical to the unstalled case; dc_dw_ready high throughout ACCUM; start and load_en pulsed while busy have no effect.
- Drop reset low during APPLY -> state returns to IDLE, all weights 0, done never pulses.

Source files
------------

// File: rtl/weight_update_pkg.sv
// Shared types and helpers for the SGD weight-update block.
// Column c of a packed row lives at the slice starting at col_lsb(c).
package weight_update_pkg;

    localparam int IDX_W = 33;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        APPLY,
        DONE
    } state_t;

    // Low bit of column c; column 0 sits in the most significant slot.
    function automatic int col_lsb(input int c, input int size, input int dw);
        return (size - 1 - c) * dw;
    endfunction

    // High bit of column c.
    function automatic int col_msb(input int c, input int size, input int dw);
        return (size - c) * dw - 1;
    endfunction

endpackage

// File: rtl/weight_row_update.sv
// Combinational SGD step on one packed row: w - (grad >>> LR_SHIFT).
// Wraps by default; WEIGHT_SATURATE_EN clamps to the signed range.
module weight_row_update #(
    parameter int DATA_SIZE = 4,
    parameter int SIZE      = 3,
    parameter int LR_SHIFT  = 1
) (
    input  logic [DATA_SIZE*SIZE-1:0] i_w,
    input  logic [DATA_SIZE*SIZE-1:0] i_grad,
    output logic [DATA_SIZE*SIZE-1:0] o_w
);
    import weight_update_pkg::*;

    for (genvar c = 0; c < SIZE; c++) begin : g_col
        localparam int LSB = col_lsb(c, SIZE, DATA_SIZE);

        logic signed [DATA_SIZE-1:0] w_old;
        logic signed [DATA_SIZE-1:0] w_grad;
        logic signed [DATA_SIZE-1:0] w_step;

        assign w_old  = i_w[LSB +: DATA_SIZE];
        assign w_grad = i_grad[LSB +: DATA_SIZE];
        assign w_step = w_grad >>> LR_SHIFT;

`ifdef WEIGHT_SATURATE_EN
        localparam logic [DATA_SIZE-1:0] MIN_V = {1'b1, {(DATA_SIZE-1){1'b0}}};
        localparam logic [DATA_SIZE-1:0] MAX_V = {1'b0, {(DATA_SIZE-1){1'b1}}};

        logic [DATA_SIZE:0] w_diff;
        logic               w_ovf;

        assign w_diff = {w_old[DATA_SIZE-1], w_old}
                      - {w_step[DATA_SIZE-1], w_step};
        assign w_ovf  = w_diff[DATA_SIZE] ^ w_diff[DATA_SIZE-1];
        assign o_w[LSB +: DATA_SIZE] = !w_ovf ? w_diff[DATA_SIZE-1:0]
                                     : (w_diff[DATA_SIZE] ? MIN_V : MAX_V);
`else
        assign o_w[LSB +: DATA_SIZE] = w_old - w_step;
`endif
    end

endmodule

// File: rtl/weight_update.sv
// Layer weight store with an SGD update fed by the per-row gradient stream.
// Optional macro WEIGHT_SATURATE_EN selects saturating subtraction.
module weight_update
    import weight_update_pkg::*;
#(
    parameter int DATA_SIZE      = 4,
    parameter int SIZE           = 3,
    parameter int MAX_LAYER_SIZE = 4,
    parameter int LR_SHIFT       = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [IDX_W-1:0]         start_layer,
    input  logic                     dc_dw_valid,
    input  logic [DATA_SIZE*SIZE-1:0] dc_dw_stream,
    output logic                     dc_dw_ready,
    input  logic                     load_en,
    input  logic [IDX_W-1:0]         load_layer,
    input  logic [IDX_W-1:0]         load_row,
    input  logic [DATA_SIZE*SIZE-1:0] load_data,
    input  logic [IDX_W-1:0]         rd_layer,
    input  logic [IDX_W-1:0]         rd_row,
    output logic [DATA_SIZE*SIZE-1:0] rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int ROW_W = DATA_SIZE * SIZE;
    localparam int RW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int LW    = (MAX_LAYER_SIZE > 1) ? $clog2(MAX_LAYER_SIZE) : 1;

    localparam logic [IDX_W-1:0] L_LIM  = IDX_W'(MAX_LAYER_SIZE);
    localparam logic [IDX_W-1:0] R_LIM  = IDX_W'(SIZE);
    localparam logic [RW-1:0]    R_LAST = RW'(SIZE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [RW-1:0]    r_row;
    logic [LW-1:0]    r_layer;
    logic             r_err;
    logic [ROW_W-1:0] r_w    [MAX_LAYER_SIZE][SIZE];
    logic [ROW_W-1:0] r_grad [SIZE];

    logic             w_accept;
    logic             w_reject;
    logic             w_load;
    logic             w_cap;
    logic             w_apply;
    logic             w_last;
    logic             w_start_ok;
    logic             w_load_ok;
    logic             w_rd_ok;
    logic [ROW_W-1:0] w_new_row;

    assign w_last     = (r_row == R_LAST);
    assign w_start_ok = (start_layer < L_LIM);
    assign w_load_ok  = (load_layer < L_LIM) && (load_row < R_LIM);
    assign w_rd_ok    = (rd_layer < L_LIM) && (rd_row < R_LIM);
    assign err        = r_err;

    assign rd_data = w_rd_ok ? r_w[rd_layer[LW-1:0]][rd_row[RW-1:0]] : '0;

    weight_row_update #(
        .DATA_SIZE (DATA_SIZE),
        .SIZE      (SIZE),
        .LR_SHIFT  (LR_SHIFT)
    ) u_row (
        .i_w    (r_w[r_layer][r_row]),
        .i_grad (r_grad[r_row]),
        .o_w    (w_new_row)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state, handshake outputs and datapath strobes.
    always_comb begin
        w_next      = r_state;
        dc_dw_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        w_apply     = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy   = 1'b0;
                w_load = load_en && w_load_ok;
                if (start) begin
                    if (w_start_ok) begin
                        w_accept = 1'b1;
                        w_next   = ACCUM;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ACCUM: begin
                dc_dw_ready = 1'b1;
                w_cap       = dc_dw_valid;
                if (dc_dw_valid && w_last) w_next = APPLY;
            end
            APPLY: begin
                w_apply = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    // Row counter and latched target layer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row   <= '0;
            r_layer <= '0;
        end else if (w_accept) begin
            r_row   <= '0;
            r_layer <= start_layer[LW-1:0];
        end else if (w_cap || w_apply) begin
            r_row   <= w_last ? '0 : r_row + 1'b1;
        end
    end

    // Rejected-start pulse, visible for the cycle after the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= 1'b0;
        else        r_err <= w_reject;
    end

    // Gradient row buffer filled from the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < SIZE; r++) r_grad[r] <= '0;
        end else if (w_cap) begin
            r_grad[r_row] <= dc_dw_stream;
        end
    end

    // Weight store: loads in IDLE, one updated row per APPLY cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < MAX_LAYER_SIZE; l++)
                for (int r = 0; r < SIZE; r++)
                    r_w[l][r] <= '0;
        end else if (w_load) begin
            r_w[load_layer[LW-1:0]][load_row[RW-1:0]] <= load_data;
        end else if (w_apply) begin
            r_w[r_layer][r_row] <= w_new_row;
        end
    end

endmodule

// File: tb/tb_weight_update.sv
// Scoreboard bench for weight_update.
// Queued expectations checked by a negedge monitor.
module tb_weight_update;

  typedef enum int {K_RD, K_BUSY, K_DONE, K_ERR, K_RDY, K_DCNT} kind_t;

  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

`ifdef WEIGHT_SATURATE_EN
  localparam logic [11:0] E_L1R0 = 12'h888;
  localparam logic [11:0] E_L2R0 = 12'h871;
`else
  localparam logic [11:0] E_L1R0 = 12'h765;
  localparam logic [11:0] E_L2R0 = 12'h681;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [32:0] start_layer;
  logic        dc_dw_valid;
  logic [11:0] dc_dw_stream;
  logic        dc_dw_ready;
  logic        load_en;
  logic [32:0] load_layer;
  logic [32:0] load_row;
  logic [11:0] load_data;
  logic [32:0] rd_layer;
  logic [32:0] rd_row;
  logic [11:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  bit   r_fin    = 1'b0;

  weight_update #(
    .DATA_SIZE      (4),
    .SIZE           (3),
    .MAX_LAYER_SIZE (4),
    .LR_SHIFT       (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_layer  (start_layer),
    .dc_dw_valid  (dc_dw_valid),
    .dc_dw_stream (dc_dw_stream),
    .dc_dw_ready  (dc_dw_ready),
    .load_en      (load_en),
    .load_layer   (load_layer),
    .load_row     (load_row),
    .load_data    (load_data),
    .rd_layer     (rd_layer),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (done === 1'b1) done_cnt++;
    while (q.size() > 0) begin
      e = q.pop_front();
      act = '0;
      case (e.kind)
        K_RD:    act = 32'(rd_data);
        K_BUSY:  act = 32'(busy);
        K_DONE:  act = 32'(done);
        K_ERR:   act = 32'(err);
        K_RDY:   act = 32'(dc_dw_ready);
        K_DCNT:  act = 32'(done_cnt);
        default: act = 'x;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #20000;
    if (!r_fin) begin
      errors++;
      $display("FAIL watchdog: wait for end of test expired");
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end
  end

  task automatic chk_now(input string n, input logic [31:0] act,
                         input logic [31:0] v);
    checks++;
    if (act !== v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string n, input kind_t k,
                          input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic rd_chk(input string n, input int l, input int r,
                        input logic [11:0] v);
    rd_layer = 33'(l);
    rd_row   = 33'(r);
    exp_push(n, K_RD, 32'(v));
    tick();
  endtask

  task automatic load(input int l, input int r, input logic [11:0] d);
    load_en    = 1'b1;
    load_layer = 33'(l);
    load_row   = 33'(r);
    load_data  = d;
    tick();
    load_en    = 1'b0;
  endtask

  task automatic run_update(input int l, input logic [11:0] g0,
                            input logic [11:0] g1,
                            input logic [11:0] g2,
                            input bit stall);
    start        = 1'b1;
    start_layer  = 33'(l);
    dc_dw_valid  = 1'b1;
    dc_dw_stream = g0;
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    exp_push("busy_accum", K_BUSY, 1);
    exp_push("rdy_accum", K_RDY, 1);
    tick();
    dc_dw_stream = g1;
    tick();
    if (stall) begin
      dc_dw_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_push("rdy_stall", K_RDY, 1);
        exp_push("busy_stall", K_BUSY, 1);
        start       = 1'b1;
        start_layer = 33'd0;
        load_en     = 1'b1;
        load_layer  = 33'(l);
        load_row    = 33'd1;
        load_data   = 12'hFFF;
        tick();
      end
      start       = 1'b0;
      load_en     = 1'b0;
      dc_dw_valid = 1'b1;
    end
    dc_dw_stream = g2;
    exp_push("rdy_last", K_RDY, 1);
    tick();
    dc_dw_valid = 1'b0;
    exp_push("rdy_apply", K_RDY, 0);
    exp_push("done_early0", K_DONE, 0);
    tick();
    exp_push("done_early1", K_DONE, 0);
    tick();
    exp_push("done_early2", K_DONE, 0);
    tick();
    exp_push("done_pulse", K_DONE, 1);
    exp_push("busy_done", K_BUSY, 1);
    tick();
    exp_push("done_after", K_DONE, 0);
    exp_push("busy_after", K_BUSY, 0);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    start_layer  = '0;
    dc_dw_valid  = 1'b0;
    dc_dw_stream = '0;
    load_en      = 1'b0;
    load_layer   = '0;
    load_row     = '0;
    load_data    = '0;
    rd_layer     = '0;
    rd_row       = '0;
    tick();
    tick();
    chk_now("rst_now_busy", 32'(busy), 0);
    chk_now("rst_now_done", 32'(done), 0);
    chk_now("rst_now_err", 32'(err), 0);
    chk_now("rst_now_rdy", 32'(dc_dw_ready), 0);
    chk_now("rst_now_rd", 32'(rd_data), 0);
    exp_push("rst_rd", K_RD, 0);
    exp_push("rst_busy", K_BUSY, 0);
    exp_push("rst_done", K_DONE, 0);
    exp_push("rst_err", K_ERR, 0);
    exp_push("rst_rdy", K_RDY, 0);
    tick();
    reset = 1'b1;
    tick();

    load(1, 0, 12'h888);
    load(1, 1, 12'h123);
    load(1, 2, 12'h456);
    run_update(1, 12'h246, 12'h000, 12'h000, 1'b0);
    rd_chk("l1r0_upd", 1, 0, E_L1R0);
    rd_chk("l1r1_keep", 1, 1, 12'h123);
    rd_chk("l1r2_keep", 1, 2, 12'h456);

    load_en    = 1'b1;
    load_layer = 33'd2;
    load_row   = 33'd0;
    load_data  = 12'h970;
    run_update(2, 12'h6EF, 12'h000, 12'h000, 1'b0);
    rd_chk("l2r0_wrap_sat", 2, 0, E_L2R0);

    start       = 1'b1;
    start_layer = 33'd4;
    tick();
    start = 1'b0;
    exp_push("err_pulse", K_ERR, 1);
    exp_push("err_busy", K_BUSY, 0);
    tick();
    exp_push("err_clear", K_ERR, 0);
    exp_push("err_busy2", K_BUSY, 0);
    rd_chk("err_nochg", 1, 0, E_L1R0);

    load(4, 0, 12'hAAA);
    load(1, 3, 12'hBBB);
    rd_chk("oor_load_l0", 0, 0, 12'h000);
    rd_chk("oor_rd_layer", 4, 0, 12'h000);
    rd_chk("oor_rd_row", 1, 3, 12'h000);
    rd_chk("oor_l1r2", 1, 2, 12'h456);

    load(3, 0, 12'h888);
    run_update(3, 12'h246, 12'h000, 12'h000, 1'b1);
    rd_chk("stall_r0", 3, 0, E_L1R0);
    rd_chk("stall_r1", 3, 1, 12'h000);
    rd_chk("stall_l0", 0, 0, 12'h000);
    exp_push("done_count3", K_DCNT, 3);
    tick();

    start        = 1'b1;
    start_layer  = 33'd1;
    dc_dw_valid  = 1'b1;
    dc_dw_stream = 12'h222;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    dc_dw_valid = 1'b0;
    tick();
    rd_layer = 33'd1;
    rd_row   = 33'd0;
    reset    = 1'b0;
    exp_push("abort_rd", K_RD, 0);
    exp_push("abort_busy", K_BUSY, 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (8) tick();
    exp_push("abort_nodone", K_DCNT, 3);
    exp_push("abort_busy2", K_BUSY, 0);
    tick();
    rd_chk("abort_l1r1", 1, 1, 12'h000);
    rd_chk("abort_l3r0", 3, 0, 12'h000);

    @(negedge clk);
    #1;
    r_fin = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
